// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 sequencer: state and round-key registers, round counter, on-the-fly key schedule.
// Latency: start accepted -> done_o after 2+NR*(1+DP_LAT) cycles; one block per 3+NR*(1+DP_LAT) cycles.
// Backpressure: start_i is taken only while ready_o=1 and dropped otherwise; `define AES_ABORT_EN adds abort_i.
module aes_round_ctrl #(
    parameter int DP_LAT = 1,
    parameter int NR     = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_i,
`ifdef AES_ABORT_EN
    input  logic         abort_i,
`endif
    input  logic [127:0] plaintext_i,
    input  logic [127:0] key_i,
    output logic         ready_o,
    output logic         done_o,
    output logic [127:0] ciphertext_o,
    output logic [127:0] dp_state_o,
    output logic [127:0] dp_rkey_o,
    output logic         dp_last_o,
    input  logic [127:0] dp_state_i,
    output logic [31:0]  sw_o,
    input  logic [31:0]  sw_i
);
    localparam logic [3:0] LAST_ROUND = 4'(NR);
    localparam logic [2:0] WAIT_LOAD  = 3'(DP_LAT - 1);

    typedef enum logic [2:0] {IDLE, INIT, KEXP, WAIT, DONE} fsm_t;

    fsm_t         fsm_q, fsm_d;
    logic [127:0] state_q;
    logic [127:0] rkey_q;
    logic [127:0] pt_q;
    logic [127:0] key_q;
    logic [3:0]   round_q;
    logic [2:0]   wait_q;
    logic         abort;
    logic [7:0]   rcon;
    logic [31:0]  w0_n, w1_n, w2_n, w3_n;

`ifdef AES_ABORT_EN
    assign abort = abort_i && (fsm_q != IDLE);
`else
    assign abort = 1'b0;
`endif

    assign ready_o    = (fsm_q == IDLE);
    assign dp_state_o = state_q;
    assign dp_rkey_o  = rkey_q;
    assign sw_o       = {rkey_q[23:0], rkey_q[31:24]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q <= IDLE;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            IDLE:    if (start_i) fsm_d = INIT;
            INIT:    fsm_d = KEXP;
            KEXP:    fsm_d = WAIT;
            WAIT:    if (wait_q == 3'd0) fsm_d = (round_q == LAST_ROUND) ? DONE : KEXP;
            DONE:    fsm_d = IDLE;
            default: fsm_d = IDLE;
        endcase
        if (abort) fsm_d = IDLE;
    end

    always_comb begin
        rcon = 8'h00;
        case (round_q)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    // Next round key; sw_i is the external S-box applied to RotWord(w3).
    assign w0_n = rkey_q[127:96] ^ sw_i ^ {rcon, 24'h000000};
    assign w1_n = rkey_q[95:64]  ^ w0_n;
    assign w2_n = rkey_q[63:32]  ^ w1_n;
    assign w3_n = rkey_q[31:0]   ^ w2_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= '0;
            rkey_q       <= '0;
            pt_q         <= '0;
            key_q        <= '0;
            round_q      <= '0;
            wait_q       <= '0;
            dp_last_o    <= 1'b0;
            done_o       <= 1'b0;
            ciphertext_o <= '0;
        end else begin
            done_o <= 1'b0;
            if (!abort) begin
                case (fsm_q)
                    IDLE: begin
                        if (start_i) begin
                            pt_q  <= plaintext_i;
                            key_q <= key_i;
                        end
                    end
                    INIT: begin
                        state_q <= pt_q ^ key_q;
                        rkey_q  <= key_q;
                        round_q <= 4'd1;
                    end
                    KEXP: begin
                        rkey_q    <= {w0_n, w1_n, w2_n, w3_n};
                        dp_last_o <= (round_q == LAST_ROUND);
                        wait_q    <= WAIT_LOAD;
                    end
                    WAIT: begin
                        if (wait_q == 3'd0) begin
                            state_q <= dp_state_i;
                            if (round_q != LAST_ROUND) round_q <= round_q + 4'd1;
                        end else begin
                            wait_q <= wait_q - 3'd1;
                        end
                    end
                    DONE: begin
                        ciphertext_o <= state_q;
                        done_o       <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: behavioural AES round + S-box models, one DUT with DP_LAT=1 and one with DP_LAT=3.
// Expected ciphertexts are queued at start and checked when done_o fires; latency and control checked directly.
module tb_aes_round_ctrl;
    localparam logic [127:0] PT1 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] K1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT1 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] RK1 = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] PT2 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K2  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT2 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         start1, start3;
    logic [127:0] pt, key;
`ifdef AES_ABORT_EN
    logic         abort;
`endif
    logic         ready1, done1, last1, ready3, done3, last3;
    logic [127:0] ct1, dps1, dprk1, dpin1, ct3, dps3, dprk3, dpin3, pipe1, pipe2;
    logic [31:0]  sw1, swr1, sw3, swr3;

    int total = 0;
    int bad   = 0;
    int dcnt1 = 0;
    int dcnt3 = 0;
    logic [127:0] sb1 [$];
    logic [127:0] sb3 [$];

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
        return (b << k) | (b >> (8 - k));
    endfunction

    // S-box from the field inverse (a^254) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] s = a;
        logic [7:0] r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            s = gmul(s, s);
            r = gmul(r, s);
        end
        if (a == 8'h00) r = 8'h00;
        return r ^ rotl8(r, 1) ^ rotl8(r, 2) ^ rotl8(r, 3) ^ rotl8(r, 4) ^ 8'h63;
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk, input logic last);
        logic [7:0]   b [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] o = '0;
        for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) t[c*4+r] = b[((c + r) % 4)*4 + r];
        for (int c = 0; c < 4; c++) begin
            a0 = t[c*4]; a1 = t[c*4+1]; a2 = t[c*4+2]; a3 = t[c*4+3];
            if (!last) begin
                t[c*4]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                t[c*4+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                t[c*4+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                t[c*4+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
            end
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
        return o ^ rk;
    endfunction

    assign swr1  = subword(sw1);
    assign swr3  = subword(sw3);
    assign dpin1 = aes_round(dps1, dprk1, last1);
    always @(posedge clk) begin
        pipe1 <= aes_round(dps3, dprk3, last3);
        pipe2 <= pipe1;
    end
    assign dpin3 = pipe2;

    aes_round_ctrl #(.DP_LAT(1), .NR(10)) dut1 (
        .clk(clk), .rst_n(rst_n), .start_i(start1),
`ifdef AES_ABORT_EN
        .abort_i(abort),
`endif
        .plaintext_i(pt), .key_i(key), .ready_o(ready1), .done_o(done1), .ciphertext_o(ct1),
        .dp_state_o(dps1), .dp_rkey_o(dprk1), .dp_last_o(last1), .dp_state_i(dpin1),
        .sw_o(sw1), .sw_i(swr1)
    );

    aes_round_ctrl #(.DP_LAT(3), .NR(10)) dut3 (
        .clk(clk), .rst_n(rst_n), .start_i(start3),
`ifdef AES_ABORT_EN
        .abort_i(1'b0),
`endif
        .plaintext_i(pt), .key_i(key), .ready_o(ready3), .done_o(done3), .ciphertext_o(ct3),
        .dp_state_o(dps3), .dp_rkey_o(dprk3), .dp_last_o(last3), .dp_state_i(dpin3),
        .sw_o(sw3), .sw_i(swr3)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_i(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done1) begin
            dcnt1++;
            check_i("sb1_expect_pending", sb1.size(), (sb1.size() > 0) ? sb1.size() : 1);
            if (sb1.size() > 0) check("ct1", ct1, sb1.pop_front());
        end
        if (done3) begin
            dcnt3++;
            check_i("sb3_expect_pending", sb3.size(), (sb3.size() > 0) ? sb3.size() : 1);
            if (sb3.size() > 0) check("ct3", ct3, sb3.pop_front());
        end
    end

    int           lat;
    logic [127:0] rk_r1;
    logic [10:0]  last_seen;

    // Caller is #1 after a rising edge with dut1 idle; lat is edges from acceptance to done_o.
    task automatic run1(input logic [127:0] p, input logic [127:0] k, input logic [127:0] e);
        pt = p; key = k; start1 = 1'b1;
        sb1.push_back(e);
        @(posedge clk); #1 start1 = 1'b0;
        lat = 0;
        last_seen = '0;
        for (int n = 1; n <= 80 && lat == 0; n++) begin
            @(posedge clk); #1;
            if (n == 2) rk_r1 = dprk1;
            if (n % 2 == 0 && n <= 20) last_seen[n/2] = last1;
            if (done1) lat = n;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, ta, tb;
        rst_n = 1'b0; start1 = 1'b0; start3 = 1'b0; pt = '0; key = '0;
`ifdef AES_ABORT_EN
        abort = 1'b0;
`endif
        #12;
        check("rst_ready1", 128'(ready1), 128'd1);
        check("rst_done1",  128'(done1),  128'd0);
        check("rst_ct1",    ct1,          '0);
        check("rst_dps1",   dps1,         '0);
        check("rst_dprk1",  dprk1,        '0);
        check("rst_last1",  128'(last1),  128'd0);
        check("rst_ready3", 128'(ready3), 128'd1);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // FIPS-197 appendix vector, round window observations on the DP_LAT=1 instance
        d0 = dcnt1;
        run1(PT1, K1, CT1);
        check_i("t1_latency", lat, 22);
        check("t2_rkey_round1", rk_r1, RK1);
        check_i("t2_last_rounds1to9", int'(last_seen[9:1]), 0);
        check("t2_last_round10", 128'(last_seen[10]), 128'd1);
        repeat (5) @(posedge clk);
        #1;
        check_i("t1_one_done_pulse", dcnt1 - d0, 1);
        check("t1_ready_idle", 128'(ready1), 128'd1);

        run1(PT2, K2, CT2);
        check_i("t3_latency_dp1", lat, 22);

        pt = PT2; key = K2; start3 = 1'b1;
        sb3.push_back(CT2);
        @(posedge clk); #1 start3 = 1'b0;
        lat = 0;
        for (int n = 1; n <= 100 && lat == 0; n++) begin
            @(posedge clk); #1;
            if (done3) lat = n;
        end
        check_i("t3_latency_dp3", lat, 42);

        // stray starts mid-run are dropped; a start held through DONE is taken in the next idle cycle
        pt = PT1; key = K1; start1 = 1'b1;
        sb1.push_back(CT1);
        sb1.push_back(CT2);
        @(posedge clk); #1 start1 = 1'b0;
        ta = 0; tb = 0;
        for (int n = 1; n <= 100 && tb == 0; n++) begin
            @(posedge clk); #1;
            if (done1) begin
                if (ta == 0) ta = n;
                else tb = n;
            end
            if (n == 10) check("t4_busy_ready", 128'(ready1), 128'd0);
            if (n == 22) check("t4_done_ready", 128'(ready1), 128'd1);
            case (n)
                5, 12: begin start1 = 1'b1; pt = ~PT2; key = ~K2; end
                6, 13: start1 = 1'b0;
                18:    begin start1 = 1'b1; pt = PT2; key = K2; end
                23:    start1 = 1'b0;
                default: ;
            endcase
        end
        check_i("t4_first_done", ta, 22);
        check_i("t4_second_done", tb, 45);

        // asynchronous reset mid-operation
        pt = PT1; key = K1; start1 = 1'b1;
        @(posedge clk); #1 start1 = 1'b0;
        repeat (9) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("t5_ready", 128'(ready1), 128'd1);
        check("t5_done",  128'(done1),  128'd0);
        check("t5_ct",    ct1,          '0);
        check("t5_dps",   dps1,         '0);
        check("t5_dprk",  dprk1,        '0);
        check("t5_last",  128'(last1),  128'd0);
        d0 = dcnt1;
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        run1(PT1, K1, CT1);
        check_i("t5_rerun_latency", lat, 22);
        repeat (3) @(posedge clk);
        #1;
        check_i("t5_done_count", dcnt1 - d0, 1);

`ifdef AES_ABORT_EN
        pt = PT2; key = K2; start1 = 1'b1;
        @(posedge clk); #1 start1 = 1'b0;
        repeat (7) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        check("t6_ready_after_abort", 128'(ready1), 128'd1);
        d0 = dcnt1;
        repeat (30) @(posedge clk);
        #1;
        check_i("t6_no_done", dcnt1 - d0, 0);
        check("t6_ct_kept", ct1, CT1);
        run1(PT1, K1, CT1);
        check_i("t6_rerun_latency", lat, 22);
`endif

        repeat (5) @(posedge clk);
        #1;
        check_i("sb1_drained", sb1.size(), 0);
        check_i("sb3_drained", sb3.size(), 0);
        check_i("dut3_done_count", dcnt3, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
